msrv32_redirect_ctrl: RTL
=========================

Name: msrv32_redirect_ctrl

Overview:
Sequences every PC redirect in the msrv32 core: taken branches/jumps from the branch unit, traps, and the post-reset boot fetch. Latches the redirect target, holds a valid/ready request to the instruction-fetch interface until accepted, then drains wrong-path fetch slots with flush/stall. Sits between the branch unit, trap logic and the PC/fetch stage.

Parameters:
RESET_PC, 32'h0000_0000, boot vector issued after reset
FLUSH_CYCLES, 1, flush/stall cycles after a redirect handshake (0..15)

Ports:
ms_riscv32_mp_clk_in  input  1  core clock, rising edge
ms_riscv32_mp_rst_n_in  input  1  asynchronous active-low reset
ex_valid_in  input  1  execute stage holds a valid instruction
branch_taken_in  input  1  branch unit result (branch taken, JAL or JALR)
target_addr_in  input  32  computed branch/jump target
trap_req_in  input  1  trap logic requests redirect
trap_pc_in  input  32  trap handler address (mtvec-derived)
imem_ready_in  input  1  fetch interface accepts redirect
redirect_valid_out  output  1  redirect request to fetch
redirect_pc_out  output  32  redirect address
flush_out  output  1  kill fetch/decode contents
stall_out  output  1  hold PC / execute stage
misaligned_instr_out  output  1  one-cycle pulse: taken target[1:0] != 0
redirect_cnt_out  output  32  count of accepted redirects

Behaviour:
- Reset is one clock domain, asynchronous assert, active-low. State BOOT; redirect_pc_out=RESET_PC; redirect_valid_out=0; flush_out=1; stall_out=1; misaligned_instr_out=0; redirect_cnt_out=0; trap_pend=0; drain counter=0.
- States: BOOT, RUN, REQ, DRAIN. All outputs are registered or decoded from registered state. No combinational input-to-output path.
- BOOT: unconditionally goes to REQ on the next edge with redirect_pc_out=RESET_PC.
- RUN: flush_out=0, stall_out=0, redirect_valid_out=0.
  - If trap_req_in=1: latch trap_pc_in and go to REQ. This takes priority over branch, and misaligned_instr_out is not pulsed.
  - Else if ex_valid_in & branch_taken_in:
    - target_addr_in[1:0]!=0: misaligned_instr_out=1 next cycle for exactly 1 cycle. No redirect; stay in RUN. Trap logic handles the exception.
    - Otherwise: latch target_addr_in and go to REQ. Redirect is visible the cycle after the taken branch (latency 1).
  - branch_taken_in with ex_valid_in=0 is ignored.
- REQ: redirect_valid_out=1, flush_out=1, stall_out=1.
  - redirect_pc_out stays stable until a handshake. Handshake = redirect_valid_out & imem_ready_in at a rising edge.
  - On handshake: redirect_cnt_out += 1, wrapping at 2^32.
    - If trap_pend=1: load the pending trap PC, clear trap_pend, stay in REQ (new request next cycle, valid stays high).
    - Else if FLUSH_CYCLES=0: go to RUN.
    - Else: load counter=FLUSH_CYCLES and go to DRAIN.
  - trap_req_in during REQ sets trap_pend=1 and captures trap_pc_in; a later trap overwrites the earlier one. Same-cycle trap and handshake: the handshake completes first, and the trap is issued as the next REQ.
  - Branch inputs are ignored outside RUN.
- DRAIN: redirect_valid_out=0, flush_out=1, stall_out=1. Counter decrements each cycle; when it reaches 1, go to RUN on the next edge, so flush lasts exactly FLUSH_CYCLES cycles. trap_req_in in DRAIN aborts the drain, latches trap_pc_in and goes to REQ.
- Reset asserted mid-operation: immediate return to BOOT values. Pending trap is discarded, and the counter is cleared.

Test Plan:
1. Reset release, RESET_PC=32'h0000_1000, imem_ready_in=1:
   - Required: BOOT 1 cycle, then redirect_valid_out=1 with redirect_pc_out=32'h1000 for 1 cycle; redirect_cnt_out=1.
   - Then flush_out=1 for 1 cycle (FLUSH_CYCLES=1), then RUN with flush_out=0 and stall_out=0.
2. RUN, ex_valid_in=1, branch_taken_in=1, target=32'h0000_2040, imem_ready_in low for 3 cycles then high:
   - Required: redirect_valid_out rises the cycle after the taken branch and stays high 4 cycles with redirect_pc_out=32'h2040 constant, then DRAIN, then RUN.
3. Taken branch with target=32'h0000_2042:
   - Required: misaligned_instr_out=1 for exactly 1 cycle; redirect_valid_out stays 0; redirect_cnt_out unchanged.
4. Same cycle: trap_req_in=1 (trap_pc=32'h0000_0100) and taken branch (target=32'h3000):
   - Required: single redirect to 32'h100; branch dropped.
5. Stuck REQ (pc=32'h3000, imem_ready_in=0), trap_req_in=1 with 32'h100:
   - Required: PC stays 32'h3000 until handshake, then a second REQ to 32'h100; count increases by 2.
   - Repeat with a trap during DRAIN (FLUSH_CYCLES=3): drain aborts and REQ to the trap PC follows next cycle.
6. Reset asserted while in REQ:
   - Required: outputs return to BOOT values asynchronously (redirect_valid_out=0, redirect_cnt_out=0); after release, boot redirect to RESET_PC.

Source files
------------

// File: rtl/msrv32_redirect_ctrl.sv
// msrv32_redirect_ctrl: sequences boot, branch and trap PC redirects into a valid/ready fetch request followed by a flush drain
module msrv32_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_n_in,
  input  logic        ex_valid_in,
  input  logic        branch_taken_in,
  input  logic [31:0] target_addr_in,
  input  logic        trap_req_in,
  input  logic [31:0] trap_pc_in,
  input  logic        imem_ready_in,
  output logic        redirect_valid_out,
  output logic [31:0] redirect_pc_out,
  output logic        flush_out,
  output logic        stall_out,
  output logic        misaligned_instr_out,
  output logic [31:0] redirect_cnt_out
);
  typedef enum logic [1:0] {BOOT, RUN, REQ, DRAIN} state_t;
  localparam logic [3:0] FLUSH_N = 4'(FLUSH_CYCLES);
  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d, trap_pc_q, trap_pc_d, cnt_q, cnt_d;
  logic        trap_pend_q, trap_pend_d, mis_q, mis_d;
  logic [3:0]  drain_q, drain_d;
  logic        hs;
  assign hs = state_q == REQ && imem_ready_in;
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    trap_pc_d   = trap_pc_q;
    trap_pend_d = trap_pend_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    mis_d       = 1'b0;
    case (state_q)
      BOOT: begin
        state_d = REQ;
        pc_d    = RESET_PC;
      end
      RUN:
        if (trap_req_in) begin
          state_d = REQ;
          pc_d    = trap_pc_in;
        end else if (ex_valid_in && branch_taken_in) begin
          if (|target_addr_in[1:0]) mis_d = 1'b1;
          else begin
            state_d = REQ;
            pc_d    = target_addr_in;
          end
        end
      REQ:
        if (hs) begin
          cnt_d       = cnt_q + 32'd1;
          trap_pend_d = 1'b0;
          if (trap_req_in || trap_pend_q) pc_d = trap_req_in ? trap_pc_in : trap_pc_q;
          else if (FLUSH_N == 4'd0) state_d = RUN;
          else begin
            state_d = DRAIN;
            drain_d = FLUSH_N;
          end
        end else if (trap_req_in) begin
          trap_pend_d = 1'b1;
          trap_pc_d   = trap_pc_in;
        end
      DRAIN:
        if (trap_req_in) begin
          state_d = REQ;
          pc_d    = trap_pc_in;
          drain_d = 4'd0;
        end else begin
          state_d = drain_q <= 4'd1 ? RUN : DRAIN;
          drain_d = drain_q <= 4'd1 ? 4'd0 : drain_q - 4'd1;
        end
      default: state_d = BOOT;
    endcase
  end
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_n_in) begin
    if (!ms_riscv32_mp_rst_n_in) begin
      state_q     <= BOOT;
      pc_q        <= RESET_PC;
      trap_pc_q   <= 32'd0;
      trap_pend_q <= 1'b0;
      cnt_q       <= 32'd0;
      drain_q     <= 4'd0;
      mis_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      trap_pc_q   <= trap_pc_d;
      trap_pend_q <= trap_pend_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      mis_q       <= mis_d;
    end
  end
  assign redirect_valid_out   = state_q == REQ;
  assign flush_out            = state_q != RUN;
  assign stall_out            = state_q != RUN;
  assign redirect_pc_out      = pc_q;
  assign misaligned_instr_out = mis_q;
  assign redirect_cnt_out     = cnt_q;
endmodule
